// File: rtl/seqdet_run_counter_pkg.sv
// Shared types and constants for the run-length sequence detector.
package seqdet_pkg;

    localparam int SEQDET_ST_W = 2;

    typedef enum logic [SEQDET_ST_W-1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_HIT  = 2'd2
    } seqdet_state_t;

    localparam logic SEQDET_MODE_CYCLE = 1'b0;
    localparam logic SEQDET_MODE_EVENT = 1'b1;

endpackage

// File: rtl/seqdet_run_counter_if.sv
// Control/data bundle between a stimulus source and the run counter.
interface seqdet_run_counter_if #(
    parameter int WIDTH = 16
);

    logic             InA;
    logic             En;
    logic             Clr;
    logic             Mode;
    logic [WIDTH-1:0] Out;
    logic             Match;
    logic             Ovf;

    modport master (
        output InA, En, Clr, Mode,
        input  Out, Match, Ovf
    );

    modport slave (
        input  InA, En, Clr, Mode,
        output Out, Match, Ovf
    );

endinterface

// File: rtl/seqdet_run_counter_counter.sv
// Occurrence counter with sticky overflow flag.
// SEQDET_SAT_EN selects saturation at all-ones; otherwise the counter wraps.
module seqdet_counter #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             ovf
);

    logic [WIDTH-1:0] count_q;
    logic             ovf_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (Clr) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (inc) begin
`ifdef SEQDET_SAT_EN
            if (&count_q) begin
                ovf_q <= 1'b1;
            end else begin
                count_q <= count_q + WIDTH'(1);
            end
`else
            count_q <= count_q + WIDTH'(1);
            if (&count_q) begin
                ovf_q <= 1'b1;
            end
`endif
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/seqdet_run_counter.sv
// Detects runs of RUN_LEN consecutive ones on InA and counts matched cycles or match events.
// Counter overflow policy is chosen by SEQDET_SAT_EN (saturate) versus default wrap.
module seqdet_run_counter
    import seqdet_pkg::*;
#(
    parameter  int WIDTH   = 16,
    parameter  int RUN_LEN = 2,
    localparam int RUN_W   = $clog2(RUN_LEN + 1)
) (
    input logic                 Clk,
    input logic                 Reset,
    seqdet_run_counter_if.slave bus
);

    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);

    seqdet_state_t    state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             matchDly_q;
    logic             match;
    logic             inc;
    logic [WIDTH-1:0] count;
    logic             ovf;

    assign match = (state_q == SEQ_HIT);

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        case (state_q)
            SEQ_IDLE: begin
                if (bus.InA) begin
                    run_d   = RUN_ONE;
                    state_d = (RUN_LEN == 1) ? SEQ_HIT : SEQ_RUN;
                end else begin
                    run_d = '0;
                end
            end
            SEQ_RUN: begin
                if (bus.InA) begin
                    run_d = run_q + RUN_ONE;
                    if ((run_q + RUN_ONE) == RUN_MAX) begin
                        state_d = SEQ_HIT;
                    end
                end else begin
                    run_d   = '0;
                    state_d = SEQ_IDLE;
                end
            end
            SEQ_HIT: begin
                // The tracker pins at RUN_LEN so long runs never overflow it.
                if (bus.InA) begin
                    run_d = RUN_MAX;
                end else begin
                    run_d   = '0;
                    state_d = SEQ_IDLE;
                end
            end
            default: begin
                run_d   = '0;
                state_d = SEQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= SEQ_IDLE;
            run_q      <= '0;
            matchDly_q <= 1'b0;
        end else if (bus.Clr) begin
            state_q    <= SEQ_IDLE;
            run_q      <= '0;
            matchDly_q <= 1'b0;
        end else if (bus.En) begin
            state_q    <= state_d;
            run_q      <= run_d;
            matchDly_q <= match;
        end
    end

    // Event mode counts only the first HIT cycle; matchDly_q follows Match in both modes.
    assign inc = bus.En & ~bus.Clr &
                 ((bus.Mode == SEQDET_MODE_EVENT) ? (match & ~matchDly_q) : match);

    seqdet_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .Clk  (Clk),
        .Reset(Reset),
        .Clr  (bus.Clr),
        .inc  (inc),
        .count(count),
        .ovf  (ovf)
    );

    assign bus.Out   = count;
    assign bus.Match = match;
    assign bus.Ovf   = ovf;

endmodule

// File: tb/tb_seqdet_run_counter.sv
// Bench for seqdet_run_counter: vector table on a RUN_LEN=3 instance, hand sequences,
// and randomized traffic on RUN_LEN=3 and RUN_LEN=1 instances against a run-count model.
module tb_seqdet_run_counter;

    localparam int W = 4;

    logic clock;
    logic reset;

    seqdet_run_counter_if #(.WIDTH(W)) ifA ();
    seqdet_run_counter_if #(.WIDTH(W)) ifB ();

    seqdet_run_counter #(.WIDTH(W), .RUN_LEN(3)) dutA (
        .Clk  (clock),
        .Reset(reset),
        .bus  (ifA)
    );

    seqdet_run_counter #(.WIDTH(W), .RUN_LEN(1)) dutB (
        .Clk  (clock),
        .Reset(reset),
        .bus  (ifB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic         inA;
        logic         en;
        logic         clr;
        logic         mode;
        logic [W-1:0] expOut;
        logic         expMatch;
        logic         expOvf;
    } vec_t;

    vec_t tbl[$];
    int   vectors = 0;
    int   errors  = 0;

    // Reference model: length of the current run of ones, previous Match, count, overflow.
    int   mOnes[2];
    bit   mPrev[2];
    int   mCount[2];
    bit   mOvf[2];
    int   runLenOf[2] = '{3, 1};

    task automatic addVec(input logic inA, en, clr, mode,
                          input int expOut, input logic expMatch);
        vec_t v;
        v.inA = inA; v.en = en; v.clr = clr; v.mode = mode;
        v.expOut = W'(expOut); v.expMatch = expMatch; v.expOvf = 1'b0;
        tbl.push_back(v);
    endtask

    task automatic applyStimulus(input logic inA, en, clr, mode);
        ifA.InA = inA; ifA.En = en; ifA.Clr = clr; ifA.Mode = mode;
        ifB.InA = inA; ifB.En = en; ifB.Clr = clr; ifB.Mode = mode;
    endtask

    task automatic checkOutput(input string name, input int idx, input int dutSel,
                               input logic [W-1:0] expOut, input logic expMatch,
                               input logic expOvf);
        logic [W-1:0] actOut;
        logic         actMatch, actOvf;
        actOut   = (dutSel == 0) ? ifA.Out   : ifB.Out;
        actMatch = (dutSel == 0) ? ifA.Match : ifB.Match;
        actOvf   = (dutSel == 0) ? ifA.Ovf   : ifB.Ovf;
        vectors++;
        if (actOut !== expOut || actMatch !== expMatch || actOvf !== expOvf) begin
            errors++;
            $display("[TB] FAIL %s #%0d dut%0d: got Out=%0d Match=%b Ovf=%b, expected Out=%0d Match=%b Ovf=%b",
                     name, idx, dutSel, actOut, actMatch, actOvf, expOut, expMatch, expOvf);
        end
    endtask

    task automatic stepEdge();
        @(posedge clock);
        #1;
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            mOnes[d] = 0; mPrev[d] = 1'b0; mCount[d] = 0; mOvf[d] = 1'b0;
        end
    endtask

    task automatic modelStep(input int d, input bit inA, en, clr, mode);
        bit match;
        bit inc;
        match = (mOnes[d] >= runLenOf[d]);
        if (clr) begin
            mOnes[d] = 0; mPrev[d] = 1'b0; mCount[d] = 0; mOvf[d] = 1'b0;
        end else if (en) begin
            inc = mode ? (match && !mPrev[d]) : match;
            if (inc) begin
                if (mCount[d] == (1 << W) - 1) begin
`ifdef SEQDET_SAT_EN
                    mOvf[d] = 1'b1;
`else
                    mCount[d] = 0;
                    mOvf[d]   = 1'b1;
`endif
                end else begin
                    mCount[d]++;
                end
            end
            mPrev[d] = match;
            mOnes[d] = inA ? ((mOnes[d] < 1000) ? mOnes[d] + 1 : 1000) : 0;
        end
    endtask

    initial begin
        logic ri, re, rc, rm;
        int   expB;

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        checkOutput("reset", 0, 0, '0, 1'b0, 1'b0);
        checkOutput("reset", 1, 1, '0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        // Five ones then zeros, cycle mode.
        addVec(1,1,0,0, 0,0); addVec(1,1,0,0, 0,0); addVec(1,1,0,0, 0,1);
        addVec(1,1,0,0, 1,1); addVec(1,1,0,0, 2,1); addVec(0,1,0,0, 3,0);
        addVec(0,1,0,0, 3,0); addVec(0,1,1,0, 0,0);
        // Event mode: one run of five, then a run of four.
        addVec(1,1,0,1, 0,0); addVec(1,1,0,1, 0,0); addVec(1,1,0,1, 0,1);
        addVec(1,1,0,1, 1,1); addVec(1,1,0,1, 1,1); addVec(0,1,0,1, 1,0);
        addVec(1,1,0,1, 1,0); addVec(1,1,0,1, 1,0); addVec(1,1,0,1, 1,1);
        addVec(1,1,0,1, 2,1); addVec(0,1,0,1, 2,0); addVec(0,1,1,0, 0,0);
        // Broken run 1,1,0 then 1,1,1,0 in event mode.
        addVec(1,1,0,1, 0,0); addVec(1,1,0,1, 0,0); addVec(0,1,0,1, 0,0);
        addVec(1,1,0,1, 0,0); addVec(1,1,0,1, 0,0); addVec(1,1,0,1, 0,1);
        addVec(0,1,0,1, 1,0); addVec(0,1,1,0, 0,0);
        // Freeze with En low mid-HIT, then Clr together with a pending increment.
        addVec(1,1,0,0, 0,0); addVec(1,1,0,0, 0,0); addVec(1,1,0,0, 0,1);
        addVec(1,1,0,0, 1,1); addVec(0,0,0,0, 1,1); addVec(0,0,0,0, 1,1);
        addVec(0,0,0,0, 1,1); addVec(1,1,1,0, 0,0); addVec(1,1,0,0, 0,0);
        addVec(1,1,0,0, 0,0); addVec(1,1,0,0, 0,1); addVec(0,1,0,0, 1,0);
        addVec(0,1,1,0, 0,0);
        // Switching to event mode during an ongoing HIT gives no increment.
        addVec(1,1,0,0, 0,0); addVec(1,1,0,0, 0,0); addVec(1,1,0,0, 0,1);
        addVec(1,1,0,0, 1,1); addVec(1,1,0,1, 1,1); addVec(1,1,0,1, 1,1);
        addVec(0,1,0,1, 1,0); addVec(0,1,1,0, 0,0);

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].inA, tbl[i].en, tbl[i].clr, tbl[i].mode);
            stepEdge();
            checkOutput("table", i, 0, tbl[i].expOut, tbl[i].expMatch, tbl[i].expOvf);
        end

        // RUN_LEN=1 instance: 18 ones in cycle mode to reach and pass all-ones.
        for (int k = 1; k <= 18; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            stepEdge();
            if (k <= 16) begin
                checkOutput("fill", k, 1, W'(k - 1), 1'b1, 1'b0);
            end else begin
`ifdef SEQDET_SAT_EN
                expB = 15;
`else
                expB = k - 17;
`endif
                checkOutput("overflow", k, 1, W'(expB), 1'b1, 1'b1);
            end
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        stepEdge();
        checkOutput("clr_with_inc", 0, 1, '0, 1'b0, 1'b0);

        // Asynchronous reset mid-HIT, then a full run is needed again.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            stepEdge();
        end
        checkOutput("pre_reset", 0, 0, W'(1), 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1 checkOutput("async_reset", 0, 0, '0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            stepEdge();
            checkOutput("post_reset", k, 0, '0, (k == 3), 1'b0);
        end

        // Randomized traffic on both instances against the model.
        @(negedge clock);
        reset = 1'b1;
        modelReset();
        @(negedge clock);
        reset = 1'b0;
        rm = 1'b0;
        for (int n = 0; n < 600; n++) begin
            ri = ($urandom_range(0, 3) != 0);
            re = ($urandom_range(0, 7) != 0);
            rc = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 15) == 0) rm = ~rm;
            applyStimulus(ri, re, rc, rm);
            stepEdge();
            for (int d = 0; d < 2; d++) begin
                modelStep(d, ri, re, rc, rm);
                checkOutput("random", n, d, W'(mCount[d]),
                            (mOnes[d] >= runLenOf[d]), mOvf[d]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
